// File: rtl/activation_share_scheduler.sv
`timescale 1ns/1ps
// Round-robin scheduler that time-shares one pipelined activation unit between NUM_REQ requesters.
// An issue register feeds the unit. An in-order tag FIFO steers each result back to the requester that issued it.
module activation_share_scheduler #(
    parameter int NUM_REQ                = 4,
    parameter int DATA_IN_0_PRECISION_0  = 16,
    parameter int DATA_OUT_0_PRECISION_0 = 32,
    parameter int MAX_OUTSTANDING        = 4
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [NUM_REQ*DATA_IN_0_PRECISION_0-1:0] req_data,
    input  logic [NUM_REQ-1:0]                       req_valid,
    output logic [NUM_REQ-1:0]                       req_ready,
    output logic [DATA_IN_0_PRECISION_0-1:0]         act_data_in_0,
    output logic                                     act_data_in_0_valid,
    input  logic                                     act_data_in_0_ready,
    input  logic [DATA_OUT_0_PRECISION_0-1:0]        act_data_out_0,
    input  logic                                     act_data_out_0_valid,
    output logic                                     act_data_out_0_ready,
    output logic [DATA_OUT_0_PRECISION_0-1:0]        resp_data,
    output logic [NUM_REQ-1:0]                       resp_valid,
    input  logic [NUM_REQ-1:0]                       resp_ready,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]     outstanding,
    output logic                                     err
);

    localparam int W     = DATA_IN_0_PRECISION_0;
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    typedef logic [ID_W-1:0]  id_t;
    typedef logic [W-1:0]     data_t;
    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [PTR_W-1:0] ptr_t;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Issue register, round-robin pointer, tag FIFO state and sticky error
    logic  issue_valid_q, issue_valid_d;
    data_t issue_data_q,  issue_data_d;
    id_t   issue_id_q,    issue_id_d;
    id_t   rr_ptr_q,      rr_ptr_d;
    cnt_t  occ_q,         occ_d;
    ptr_t  wr_ptr_q,      wr_ptr_d;
    ptr_t  rd_ptr_q,      rd_ptr_d;
    logic  err_q,         err_d;
    id_t   tag_mem [MAX_OUTSTANDING];

    logic           handoff;
    logic           slot_free;
    logic [CNT_W:0] inflight;
    logic           credit_ok;
    logic           arb_en;
    id_t            cand;
    logic           grant;
    id_t            grant_id;
    data_t          grant_data;
    logic           fifo_empty;
    id_t            head_id;
    logic           out_ready;
    logic           push;
    logic           pop;

    assign handoff   = issue_valid_q & act_data_in_0_ready;
    assign slot_free = ~issue_valid_q | handoff;

    // A pending issue always holds a credit: it is pushed into the FIFO on the cycle it hands off.
    assign inflight  = {1'b0, occ_q} + {{CNT_W{1'b0}}, issue_valid_q};
    assign credit_ok = inflight < (CNT_W + 1)'(MAX_OUTSTANDING);
    assign arb_en    = ~rst & slot_free & credit_ok;

    // NOTE: defaults are assigned first so every path writes every signal and no latch is inferred.
    always_comb begin
        cand     = rr_ptr_q;
        grant    = 1'b0;
        grant_id = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = (cand == id_t'(NUM_REQ - 1)) ? '0 : cand + id_t'(1);
            if (arb_en && !grant && req_valid[cand]) begin
                grant    = 1'b1;
                grant_id = cand;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (grant) req_ready[grant_id] = 1'b1;
    end

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == id_t'(i)) grant_data = req_data[i*W +: W];
        end
    end

    always_comb begin
        issue_valid_d = issue_valid_q;
        issue_data_d  = issue_data_q;
        issue_id_d    = issue_id_q;
        rr_ptr_d      = rr_ptr_q;
        if (handoff) issue_valid_d = 1'b0;
        if (grant) begin
            issue_valid_d = 1'b1;
            issue_data_d  = grant_data;
            issue_id_d    = grant_id;
            rr_ptr_d      = grant_id;
        end
    end

    assign fifo_empty = (occ_q == cnt_t'(0));
    assign head_id    = tag_mem[rd_ptr_q];

    // An orphan result (empty FIFO) is accepted so it is dropped instead of wedging the unit.
    assign out_ready = fifo_empty ? act_data_out_0_valid : resp_ready[head_id];
    assign push      = handoff;
    assign pop       = act_data_out_0_valid & out_ready & ~fifo_empty;

    always_comb begin
        occ_d    = occ_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({push, pop})
            2'b10:   occ_d = occ_q + cnt_t'(1);
            2'b01:   occ_d = occ_q - cnt_t'(1);
            default: occ_d = occ_q;
        endcase
        err_d = err_q | (act_data_out_0_valid & fifo_empty);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            issue_valid_q <= 1'b0;
            issue_data_q  <= '0;
            issue_id_q    <= '0;
            rr_ptr_q      <= id_t'(NUM_REQ - 1);
            occ_q         <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            err_q         <= 1'b0;
        end else begin
            issue_valid_q <= issue_valid_d;
            issue_data_q  <= issue_data_d;
            issue_id_q    <= issue_id_d;
            rr_ptr_q      <= rr_ptr_d;
            occ_q         <= occ_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            err_q         <= err_d;
        end
    end

    // NOTE: tag storage has no reset; the pointers and occupancy alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (push) tag_mem[wr_ptr_q] <= issue_id_q;
    end

    always_comb begin
        resp_valid = '0;
        if (!rst && act_data_out_0_valid && !fifo_empty) resp_valid[head_id] = 1'b1;
    end

    assign act_data_in_0        = rst ? '0   : issue_data_q;
    assign act_data_in_0_valid  = ~rst & issue_valid_q;
    assign act_data_out_0_ready = ~rst & out_ready;
    assign resp_data            = rst ? '0   : act_data_out_0;
    assign outstanding          = rst ? '0   : occ_q;
    assign err                  = ~rst & err_q;

endmodule

// File: tb/tb_activation_share_scheduler.sv
`timescale 1ns/1ps
// Directed bench for activation_share_scheduler. Two instances are used: one with a 2-cycle identity
// unit stub and MAX_OUTSTANDING=4, and one with a 6-cycle stub and MAX_OUTSTANDING=2.
module tb_activation_share_scheduler;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int WO = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // ---------------- instance A: MAX_OUTSTANDING=4, 2-cycle unit ----------------
    logic [N*W-1:0] req_data_a;
    logic [N-1:0]   req_valid_a, req_ready_a, resp_valid_a, resp_ready_a;
    logic [W-1:0]   act_in_a;
    logic           act_in_valid_a, act_in_ready_a;
    logic [WO-1:0]  act_out_a, resp_data_a, inj_data;
    logic           act_out_valid_a, act_out_ready_a, err_a, inj_valid, unit_rdy_a;
    logic [2:0]     outstanding_a;
    logic           ua_valid;
    logic [W-1:0]   ua_data;

    assign act_in_ready_a  = unit_rdy_a;
    assign act_out_valid_a = ua_valid | inj_valid;
    assign act_out_a       = inj_valid ? inj_data : {{(WO-W){ua_data[W-1]}}, ua_data};

    activation_share_scheduler #(
        .NUM_REQ(N), .DATA_IN_0_PRECISION_0(W), .DATA_OUT_0_PRECISION_0(WO), .MAX_OUTSTANDING(4)
    ) dut (
        .clk(clk), .rst(rst),
        .req_data(req_data_a), .req_valid(req_valid_a), .req_ready(req_ready_a),
        .act_data_in_0(act_in_a), .act_data_in_0_valid(act_in_valid_a), .act_data_in_0_ready(act_in_ready_a),
        .act_data_out_0(act_out_a), .act_data_out_0_valid(act_out_valid_a), .act_data_out_0_ready(act_out_ready_a),
        .resp_data(resp_data_a), .resp_valid(resp_valid_a), .resp_ready(resp_ready_a),
        .outstanding(outstanding_a), .err(err_a)
    );

    logic [W-1:0] qa_data [$];
    int           qa_time [$];
    int           cyc_a;

    always @(posedge clk) begin
        if (rst) begin
            qa_data.delete();
            qa_time.delete();
            ua_valid <= 1'b0;
            ua_data  <= '0;
            cyc_a    <= 0;
        end else begin
            if (ua_valid && act_out_ready_a) begin
                void'(qa_data.pop_front());
                void'(qa_time.pop_front());
            end
            if (act_in_valid_a && act_in_ready_a) begin
                qa_data.push_back(act_in_a);
                qa_time.push_back(cyc_a + 2);
            end
            ua_valid <= (qa_data.size() > 0) ? (qa_time[0] <= cyc_a + 1) : 1'b0;
            ua_data  <= (qa_data.size() > 0) ? qa_data[0] : '0;
            cyc_a    <= cyc_a + 1;
        end
    end

    // ---------------- instance B: MAX_OUTSTANDING=2, 6-cycle unit ----------------
    logic [N*W-1:0] req_data_b;
    logic [N-1:0]   req_valid_b, req_ready_b, resp_valid_b, resp_ready_b;
    logic [W-1:0]   act_in_b;
    logic           act_in_valid_b, act_in_ready_b, act_out_ready_b, err_b;
    logic [WO-1:0]  act_out_b, resp_data_b;
    logic [1:0]     outstanding_b;
    logic           ub_valid;
    logic [W-1:0]   ub_data;

    assign act_in_ready_b = 1'b1;
    assign act_out_b      = {{(WO-W){ub_data[W-1]}}, ub_data};

    activation_share_scheduler #(
        .NUM_REQ(N), .DATA_IN_0_PRECISION_0(W), .DATA_OUT_0_PRECISION_0(WO), .MAX_OUTSTANDING(2)
    ) dut_b (
        .clk(clk), .rst(rst),
        .req_data(req_data_b), .req_valid(req_valid_b), .req_ready(req_ready_b),
        .act_data_in_0(act_in_b), .act_data_in_0_valid(act_in_valid_b), .act_data_in_0_ready(act_in_ready_b),
        .act_data_out_0(act_out_b), .act_data_out_0_valid(ub_valid), .act_data_out_0_ready(act_out_ready_b),
        .resp_data(resp_data_b), .resp_valid(resp_valid_b), .resp_ready(resp_ready_b),
        .outstanding(outstanding_b), .err(err_b)
    );

    logic [W-1:0] qb_data [$];
    int           qb_time [$];
    int           cyc_b;

    always @(posedge clk) begin
        if (rst) begin
            qb_data.delete();
            qb_time.delete();
            ub_valid <= 1'b0;
            ub_data  <= '0;
            cyc_b    <= 0;
        end else begin
            if (ub_valid && act_out_ready_b) begin
                void'(qb_data.pop_front());
                void'(qb_time.pop_front());
            end
            if (act_in_valid_b && act_in_ready_b) begin
                qb_data.push_back(act_in_b);
                qb_time.push_back(cyc_b + 6);
            end
            ub_valid <= (qb_data.size() > 0) ? (qb_time[0] <= cyc_b + 1) : 1'b0;
            ub_data  <= (qb_data.size() > 0) ? qb_data[0] : '0;
            cyc_b    <= cyc_b + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int hist [6];
        int win;
        int issues_total;
        int gseq [$];

        rst          = 1'b1;
        req_data_a   = {16'd4, 16'd3, 16'd2, 16'hFFF8};
        req_valid_a  = 4'b0001;
        resp_ready_a = 4'hF;
        unit_rdy_a   = 1'b1;
        inj_valid    = 1'b0;
        inj_data     = '0;
        req_data_b   = {16'd4, 16'd3, 16'd2, 16'd1};
        req_valid_b  = '0;
        resp_ready_b = 4'hF;

        // Scenario 1: reset then a single request from requester 0
        next_cycle(); #1;
        check("rst_req_ready",     req_ready_a,     0);
        check("rst_act_valid",     act_in_valid_a,  0);
        check("rst_act_data",      act_in_a,        0);
        check("rst_resp_valid",    resp_valid_a,    0);
        check("rst_outstanding",   outstanding_a,   0);
        check("rst_err",           err_a,           0);
        check("rst_out_ready",     act_out_ready_a, 0);
        next_cycle(); rst = 1'b0; #1;
        check("s1_grant0",         req_ready_a,     4'b0001);
        next_cycle(); req_valid_a = '0; #1;
        check("s1_act_valid",      act_in_valid_a,  1);
        check("s1_act_data",       act_in_a,        16'hFFF8);
        check("s1_no_regrant",     req_ready_a,     0);
        next_cycle(); #1;
        check("s1_outstanding1",   outstanding_a,   1);
        next_cycle(); #1;
        check("s1_resp_valid",     resp_valid_a,    4'b0001);
        check("s1_resp_data",      resp_data_a,     32'hFFFF_FFF8);
        check("s1_out_ready",      act_out_ready_a, 1);
        next_cycle(); #1;
        check("s1_drained",        outstanding_a,   0);
        check("s1_resp_idle",      resp_valid_a,    0);

        // Scenario 3: credit limit on instance B (grants at c0,c1,c8,c9,c16,c17)
        foreach (hist[i]) hist[i] = 0;
        issues_total = 0;
        next_cycle(); req_valid_b = '1; #1;
        for (int c = 0; c < 24; c++) begin
            check("s3_outstanding_le2", outstanding_b > 2'd2, 0);
            for (int i = 5; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = act_in_valid_b ? 1 : 0;
            win = 0;
            foreach (hist[i]) win += hist[i];
            check("s3_window_le2", win > 2, 0);
            issues_total += hist[0];
            for (int i = 0; i < N; i++) if (req_ready_b[i]) gseq.push_back(i);
            next_cycle(); #1;
        end
        req_valid_b = '0;
        check("s3_issue_total", issues_total, 6);
        check("s3_grant_count", gseq.size(), 6);
        for (int i = 0; i < gseq.size() && i < 6; i++) check("s3_grant_order", gseq[i], i % 4);

        // Scenario 2: round-robin fairness after a fresh reset
        next_cycle(); rst = 1'b1;
        next_cycle(); rst = 1'b0;
        req_data_a  = {16'd4, 16'd3, 16'd2, 16'd1};
        req_valid_a = '1;
        #1;
        for (int k = 0; k < 15; k++) begin
            if (k > 0) begin
                next_cycle();
                if (k == 12) req_valid_a = '0;
                #1;
            end
            check("s2_grant", req_ready_a, (k < 12) ? (32'd1 << (k % 4)) : 32'd0);
            if (k >= 3) begin
                check("s2_resp_valid", resp_valid_a, 32'd1 << ((k - 3) % 4));
                check("s2_resp_data",  resp_data_a,  ((k - 3) % 4) + 1);
            end
        end
        repeat (3) next_cycle();

        // Unit input backpressure holds the issue register and blocks new grants
        unit_rdy_a = 1'b0; req_valid_a = 4'b1001; #1;
        check("bp_grant0",        req_ready_a,    4'b0001);
        for (int s = 0; s < 2; s++) begin
            next_cycle(); #1;
            check("bp_no_grant",  req_ready_a,    0);
            check("bp_hold_valid", act_in_valid_a, 1);
            check("bp_hold_data", act_in_a,       16'd1);
        end
        next_cycle(); unit_rdy_a = 1'b1; #1;
        check("bp_grant3",        req_ready_a,    4'b1000);
        next_cycle(); req_valid_a = '0; #1;
        check("bp_act_data3",     act_in_a,       16'd4);
        repeat (5) next_cycle();
        #1;
        check("bp_drained",       outstanding_a,  0);

        // Scenario 4: response backpressure on requester 1
        next_cycle(); resp_ready_a = 4'b1101; req_valid_a = 4'b0110; #1;
        check("s4_grant1",        req_ready_a,    4'b0010);
        next_cycle(); #1;
        check("s4_grant2",        req_ready_a,    4'b0100);
        next_cycle(); req_valid_a = '0; #1;
        check("s4_act_data2",     act_in_a,       16'd3);
        for (int s = 0; s < 5; s++) begin
            next_cycle(); #1;
            check("s4_stall_valid", resp_valid_a,    4'b0010);
            check("s4_stall_ready", act_out_ready_a, 0);
            check("s4_stall_data",  resp_data_a,     2);
            check("s4_stall_occ",   outstanding_a,   2);
        end
        next_cycle(); resp_ready_a = 4'hF; #1;
        check("s4_rel_valid",     resp_valid_a,    4'b0010);
        check("s4_rel_ready",     act_out_ready_a, 1);
        check("s4_rel_data",      resp_data_a,     2);
        next_cycle(); #1;
        check("s4_id2_valid",     resp_valid_a,    4'b0100);
        check("s4_id2_data",      resp_data_a,     3);
        next_cycle(); #1;
        check("s4_idle",          resp_valid_a,    0);
        check("s4_drained",       outstanding_a,   0);

        // Scenario 5: reset with three elements outstanding
        next_cycle(); resp_ready_a = '0; req_valid_a = '1; #1;
        check("s5_grant3",        req_ready_a,    4'b1000);
        next_cycle(); #1;
        check("s5_grant0",        req_ready_a,    4'b0001);
        next_cycle(); #1;
        check("s5_grant1",        req_ready_a,    4'b0010);
        next_cycle(); req_valid_a = '0;
        next_cycle(); #1;
        check("s5_occ3",          outstanding_a,  3);
        check("s5_head_valid",    resp_valid_a,   4'b1000);
        next_cycle(); rst = 1'b1; #1;
        check("s5_rst_occ",       outstanding_a,  0);
        check("s5_rst_resp",      resp_valid_a,   0);
        check("s5_rst_act",       act_in_valid_a, 0);
        next_cycle(); rst = 1'b0; req_valid_a = '1; resp_ready_a = '1; #1;
        check("s5_post_occ",      outstanding_a,  0);
        check("s5_post_resp",     resp_valid_a,   0);
        check("s5_post_grant0",   req_ready_a,    4'b0001);
        next_cycle(); req_valid_a = '0; #1;
        check("s5_post_data",     act_in_a,       16'd1);
        repeat (5) next_cycle();

        // Scenario 6: orphan result with an empty tag FIFO
        #1;
        check("s6_err_before",    err_a,           0);
        check("s6_occ_empty",     outstanding_a,   0);
        next_cycle(); inj_valid = 1'b1; inj_data = 32'h0000_1234; #1;
        check("s6_resp_valid",    resp_valid_a,    0);
        check("s6_out_ready",     act_out_ready_a, 1);
        check("s6_err_pre_edge",  err_a,           0);
        next_cycle(); inj_valid = 1'b0; #1;
        check("s6_err_set",       err_a,           1);
        check("s6_resp_idle",     resp_valid_a,    0);
        repeat (3) next_cycle();
        #1;
        check("s6_err_sticky",    err_a,           1);
        check("s6_b_no_err",      err_b,           0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
